// File: rtl/alu_arbiter_pkg.sv
// Shared alu_func definitions for the ALU arbiter slice.
// Holds the FuncCode constants, the arbiter FSM state encoding
// and a small owner-index helper used by the top level.
package alu_arbiter_pkg;

    // FuncCode values understood by the alu; any other code yields zero.
    localparam logic [3:0] FUNC_ADD = 4'h0;
    localparam logic [3:0] FUNC_SUB = 4'h1;
    localparam logic [3:0] FUNC_AND = 4'h2;
    localparam logic [3:0] FUNC_OR  = 4'h3;
    localparam logic [3:0] FUNC_XOR = 4'h4;
    localparam logic [3:0] FUNC_NOT = 4'h5;

    // Arbiter FSM states: one operation in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // One-hot vector for a requester index (0 or 1).
    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters of the arbiter.
// OverflowFlag reports two's-complement overflow for ADD/SUB and is
// zero for logic operations and unknown codes.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [3:0]            func,
    output logic [data_width-1:0] c,
    output logic                  ovf
);

    localparam int MSB = data_width - 1;

    // Decode FuncCode into result and signed-overflow flag.
    always_comb begin
        c   = '0;
        ovf = 1'b0;
        case (func)
            FUNC_ADD: begin
                c   = a + b;
                ovf = (a[MSB] == b[MSB]) && (c[MSB] != a[MSB]);
            end
            FUNC_SUB: begin
                c   = a - b;
                ovf = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB]);
            end
            FUNC_AND: c = a & b;
            FUNC_OR:  c = a | b;
            FUNC_XOR: c = a ^ b;
            FUNC_NOT: c = ~a;
            default: begin
                c   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared alu.
// Sequence per operation: IDLE (grant/accept) -> EXEC (compute and
// register result) -> RESP (hold result until the owner takes it).
// Ties are round-robin; defining ALU_ARBITER_FIXED_PRIO_EN makes
// requester 0 always win ties instead.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [data_width-1:0] req_a0,
    input  logic [data_width-1:0] req_b0,
    input  logic [data_width-1:0] req_a1,
    input  logic [data_width-1:0] req_b1,
    input  logic [3:0]            req_func0,
    input  logic [3:0]            req_func1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [data_width-1:0] rsp_c,
    output logic                  rsp_ovf,
    output logic                  busy
);

    arb_state_t            state_reg;
    arb_state_t            state_next;
    logic                  owner_reg;
    logic [data_width-1:0] a_reg;
    logic [data_width-1:0] b_reg;
    logic [3:0]            func_reg;
    logic [data_width-1:0] rsp_c_reg;
    logic                  rsp_ovf_reg;

    logic                  grant_idx;
    logic                  accept;
    logic [data_width-1:0] alu_c;
    logic                  alu_ovf;

    // Per-requester views of the operand ports, indexable by grant.
    logic [data_width-1:0] req_a    [2];
    logic [data_width-1:0] req_b    [2];
    logic [3:0]            req_func [2];

    assign req_a[0]    = req_a0;
    assign req_a[1]    = req_a1;
    assign req_b[0]    = req_b0;
    assign req_b[1]    = req_b1;
    assign req_func[0] = req_func0;
    assign req_func[1] = req_func1;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it asks.
    always_comb begin
        grant_idx = req_valid[0] ? 1'b0 : 1'b1;
    end
`else
    logic last_grant_reg;

    // Round-robin: on a tie, grant whoever was not granted last.
    always_comb begin
        grant_idx = req_valid[0] ? 1'b0 : 1'b1;
        if (&req_valid) begin
            grant_idx = ~last_grant_reg;
        end
    end

    // Last-grant pointer moves only when a request is actually taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= grant_idx;
        end
    end
`endif

    // Ready only in IDLE, only to the granted requester that is asking.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && !reset &&
                                   req_valid[gi] && (grant_idx == gi[0]);
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    alu #(
        .data_width(data_width)
    ) aluInst (
        .a    (a_reg),
        .b    (b_reg),
        .func (func_reg),
        .c    (alu_c),
        .ovf  (alu_ovf)
    );

    // Next-state logic; the non-owner rsp_ready bit is ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the granted request on accept; register alu output in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg   <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            func_reg    <= '0;
            rsp_c_reg   <= '0;
            rsp_ovf_reg <= 1'b0;
        end else begin
            if (accept) begin
                owner_reg <= grant_idx;
                a_reg     <= req_a[grant_idx];
                b_reg     <= req_b[grant_idx];
                func_reg  <= req_func[grant_idx];
            end
            if (state_reg == EXEC) begin
                rsp_c_reg   <= alu_c;
                rsp_ovf_reg <= alu_ovf;
            end
        end
    end

    assign rsp_valid = (state_reg == RESP) ? owner_onehot(owner_reg) : 2'b00;
    assign rsp_c     = rsp_c_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a
// randomized run checked against a behavioural model of arbitration
// and arithmetic.
module tb_alu_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]    req_func0, req_func1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_c;
    logic          rsp_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.data_width(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_func0 (req_func0),
        .req_func1 (req_func1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    // Reference arithmetic from signed integer ranges.
    function automatic void ref_alu(input logic [3:0] f, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b,
                                    output logic [DW-1:0] c, output logic o);
        int sa, sb, s;
        logic [31:0] t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = '0;
        o = 1'b0;
        case (f)
            4'd0: begin s = sa + sb; t = s; c = t[DW-1:0]; o = (s > 32767) || (s < -32768); end
            4'd1: begin s = sa - sb; t = s; c = t[DW-1:0]; o = (s > 32767) || (s < -32768); end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = a ^ b;
            4'd5: c = ~a;
            default: c = '0;
        endcase
    endfunction

    function automatic int tie_winner(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_func0 = 4'd0; req_func1 = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_last = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        mid();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_c !== 16'h0000) begin errors++; $display("FAIL reset_rsp_c: got %h expected 0000", rsp_c); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf); end
        req_valid = 2'b00;
        reset = 1'b0;
        model_last = 1;
        tick();
        $display("txn reset: idle outputs checked");
    endtask

    task automatic test_add_overflow();
        do_reset();
        req_a0 = 16'h7FFF; req_b0 = 16'h0001; req_func0 = 4'd0;
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        mid();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready: got %b expected 01", req_ready); end
        tick();
        req_valid = 2'b00;
        mid();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec_rsp_valid: got %b expected 00", rsp_valid); end
        tick();
        mid();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_c !== 16'h8000) begin errors++; $display("FAIL add_rsp_c: got %h expected 8000", rsp_c); end
        checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL add_rsp_ovf: got %b expected 1", rsp_ovf); end
        tick();
        mid();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_done_busy: got %b expected 0", busy); end
        model_last = 0;
        rsp_ready = 2'b00;
        $display("txn add_overflow: c=%h ovf=%b", rsp_c, rsp_ovf);
    endtask

    task automatic test_round_robin();
        do_reset();
        req_a0 = 16'h0005; req_b0 = 16'h0003; req_func0 = 4'd1;
        req_a1 = 16'h00F0; req_b1 = 16'h0FF0; req_func1 = 4'd2;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        mid();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b expected 01", req_ready); end
        tick();
`ifdef ALU_ARBITER_FIXED_PRIO_EN
        req_valid = 2'b10;
`endif
        mid();
        tick();
        mid();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rr_rsp0_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_c !== 16'h0002) begin errors++; $display("FAIL rr_rsp0_c: got %h expected 0002", rsp_c); end
        tick();
        mid();
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b00;
        mid();
        tick();
        mid();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rr_rsp1_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_c !== 16'h00F0) begin errors++; $display("FAIL rr_rsp1_c: got %h expected 00f0", rsp_c); end
        tick();
        rsp_ready = 2'b00;
        model_last = 1;
        $display("txn round_robin: req0 then req1 served");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ec;
        logic          eo;
        do_reset();
        req_a1 = DW'($urandom); req_b1 = DW'($urandom); req_func1 = 4'd4;
        ref_alu(4'd4, req_a1, req_b1, ec, eo);
        req_valid = 2'b10;
        mid();
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
        tick();
        req_valid = 2'b11;
        req_a1 = ~req_a1;
        rsp_ready = 2'b01;
        mid();
        tick();
        for (int k = 0; k < 5; k++) begin
            mid();
            checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 10", k, rsp_valid); end
            checks++; if (rsp_c !== ec) begin errors++; $display("FAIL bp_rsp_c[%0d]: got %h expected %h", k, rsp_c, ec); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", k, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", k, busy); end
            tick();
        end
        rsp_ready = 2'b10;
        req_valid = 2'b00;
        mid();
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL bp_final_valid: got %b expected 10", rsp_valid); end
        tick();
        mid();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_done_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_done_valid: got %b expected 00", rsp_valid); end
        rsp_ready = 2'b00;
        model_last = 1;
        $display("txn backpressure: xor c=%h held 5 cycles", ec);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_a0 = 16'h1234; req_b0 = 16'h1111; req_func0 = 4'd0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        reset = 1'b1;
        mid();
        tick();
        reset = 1'b0;
        model_last = 1;
        rsp_ready = 2'b11;
        mid();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_c !== 16'h0000) begin errors++; $display("FAIL rst_mid_c: got %h expected 0000", rsp_c); end
        for (int k = 0; k < 3; k++) begin
            tick();
            mid();
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_no_rsp[%0d]: got %b expected 00", k, rsp_valid); end
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_mid_ptr: got %b expected 01", req_ready); end
        tick();
        idle_inputs();
        do_reset();
        $display("txn reset_midflight: op discarded");
    endtask

    task automatic test_ties();
        int g;
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int n = 0; n < 3; n++) begin
            g = tie_winner(2'b11, model_last);
            mid();
            checks++; if (req_ready !== ((g == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_grant[%0d]: got %b expected requester %0d", n, req_ready, g); end
            tick();
            model_last = g;
            mid();
            tick();
            mid();
            checks++; if (rsp_valid !== ((g == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_rsp[%0d]: got %b expected requester %0d", n, rsp_valid, g); end
            $display("txn tie %0d: granted requester %0d", n, g);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [1:0]    v;
        int            g, d;
        logic [DW-1:0] ga, gb, ec;
        logic [3:0]    gf;
        logic          eo;
        logic [1:0]    oh;
        idle_inputs();
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            req_a0 = DW'($urandom); req_b0 = DW'($urandom);
            req_a1 = DW'($urandom); req_b1 = DW'($urandom);
            req_func0 = 4'($urandom_range(0, 15)); req_func1 = 4'($urandom_range(0, 15));
            req_valid = v;
            rsp_ready = 2'b00;
            g  = tie_winner(v, model_last);
            oh = (g == 0) ? 2'b01 : 2'b10;
            ga = (g == 0) ? req_a0 : req_a1;
            gb = (g == 0) ? req_b0 : req_b1;
            gf = (g == 0) ? req_func0 : req_func1;
            ref_alu(gf, ga, gb, ec, eo);
            mid();
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, req_ready, oh); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle_busy[%0d]: got %b expected 0", n, busy); end
            tick();
            model_last = g;
            req_valid = 2'($urandom);
            req_a0 = DW'($urandom); req_b0 = DW'($urandom);
            req_a1 = DW'($urandom); req_b1 = DW'($urandom);
            req_func0 = 4'($urandom); req_func1 = 4'($urandom);
            mid();
            checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL rnd_exec[%0d]: got valid=%b ready=%b busy=%b expected 00/00/1", n, rsp_valid, req_ready, busy);
            end
            d = $urandom_range(0, 3);
            rsp_ready = ~oh & 2'($urandom);
            tick();
            for (int k = 0; k <= d; k++) begin
                if (k == d) rsp_ready[g] = 1'b1;
                mid();
                checks++; if (rsp_valid !== oh) begin errors++; $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", n, rsp_valid, oh); end
                checks++; if (rsp_c !== ec || rsp_ovf !== eo) begin errors++; $display("FAIL rnd_result[%0d]: got c=%h ovf=%b expected c=%h ovf=%b", n, rsp_c, rsp_ovf, ec, eo); end
                tick();
            end
            req_valid = 2'b00;
            rsp_ready = 2'b00;
            $display("txn rnd %0d: owner=%0d func=%0h a=%h b=%h c=%h ovf=%b wait=%0d", n, g, gf, ga, gb, ec, eo, d);
        end
        mid();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_end_busy: got %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_add_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_ties();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
